// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One write-back request toward the register-file port.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register select; x0 never maps to a scoreboard bit.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        oh[0]  = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter: ALU has fixed priority, the long unit is protected
// from starvation by requesting an issue bubble after STARVE_LIMIT refusals.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    output logic                  lu_accept,
    output logic                  sel_valid,
    output logic [REG_ADDR_W-1:0] sel_rd,
    output logic [XLEN-1:0]       sel_data,
    output logic                  bubble
);

    // Counter runs one past the limit so the bubble lasts a single cycle:
    // the cycle after the bubble has no ALU write-back and the long unit wins.
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] SAT   = CW'(STARVE_LIMIT + 1);

    wb_req_t alu_req, lu_req, sel;
    logic [CW-1:0] starve_cnt;

    // Priority mux: ALU first, then long unit; nothing passes during reset.
    always_comb begin
        alu_req   = '{valid: alu_valid, rd: alu_rd, data: alu_data};
        lu_req    = '{valid: lu_valid,  rd: lu_rd,  data: lu_data};
        lu_ready  = rst_n && !alu_valid;
        lu_accept = lu_valid && lu_ready;
        sel       = '0;
        if (rst_n) begin
            if (alu_req.valid)     sel = alu_req;
            else if (lu_req.valid) sel = lu_req;
        end
        sel_valid = sel.valid;
        sel_rd    = sel.rd;
        sel_data  = sel.data;
        bubble    = rst_n && (starve_cnt == LIMIT);
    end

    // Count consecutive refused long write-backs, saturating past the limit.
    always_ff @(posedge clk) begin
        if (!rst_n)                     starve_cnt <= '0;
        else if (!lu_valid || lu_accept) starve_cnt <= '0;
        else if (starve_cnt != SAT)     starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Issue scoreboard and register-file write-back controller.
// Holds the busy bits, the outstanding long-op count, hazard detection and
// a sticky protocol-error flag; the write-port mux lives in rf_wb_arbiter.
module rf_wb_scoreboard
    import rf_pkg::*;
#(
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    input  logic                  issue_long,
    input  logic                  alu_wb_valid,
    input  logic [REG_ADDR_W-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]       alu_wb_data,
    input  logic                  lu_wb_valid,
    output logic                  lu_wb_ready,
    input  logic [REG_ADDR_W-1:0] lu_wb_rd,
    input  logic [XLEN-1:0]       lu_wb_data,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [XLEN-1:0]       rf_write_data,
    output logic                  rf_write_enable,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  sb_error
);

    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

    logic [NUM_REGS-1:0] busy;
    logic [3:0]          pending;
    logic                short_q;   // a short op issued last cycle
    logic                wr_valid, lu_accept, bubble, hazard, issue_fire;
    logic [REG_ADDR_W-1:0] wr_rd;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic                err_now;

    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_wb_valid),
        .alu_rd    (alu_wb_rd),
        .alu_data  (alu_wb_data),
        .lu_valid  (lu_wb_valid),
        .lu_rd     (lu_wb_rd),
        .lu_data   (lu_wb_data),
        .lu_ready  (lu_wb_ready),
        .lu_accept (lu_accept),
        .sel_valid (wr_valid),
        .sel_rd    (wr_rd),
        .sel_data  (rf_write_data),
        .bubble    (bubble)
    );

    // Hazards use registered state only; a write-back landing this cycle
    // does not release a dependent issue until the following cycle.
    always_comb begin
        hazard = busy[issue_rs1] || busy[issue_rs2]
              || (issue_rd_we && busy[issue_rd])
              || (issue_long && pending == PEND_MAX)
              || bubble;
        issue_ready     = rst_n && !hazard;
        issue_fire      = issue_valid && issue_ready;
        rf_write_reg    = wr_rd;
        rf_write_enable = wr_valid && (wr_rd != '0);
        set_mask        = (issue_fire && issue_rd_we) ? rd_onehot(issue_rd) : '0;
        clr_mask        = wr_valid ? rd_onehot(wr_rd) : '0;
        err_now         = (wr_valid && wr_rd != '0 && !busy[wr_rd])
                       || (lu_accept && pending == '0)
                       || (alu_wb_valid && !short_q);
        busy_mask       = busy;
    end

    // Scoreboard, pending count and error flag update on the write edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            pending  <= '0;
            short_q  <= 1'b0;
            sb_error <= 1'b0;
        end else begin
            busy    <= (busy | set_mask) & ~clr_mask;
            short_q <= issue_fire && !issue_long;
            case ({issue_fire && issue_long, lu_accept && pending != '0})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
            if (err_now) sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard with hand-computed expectations.
module tb_rf_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we, issue_long;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        lu_wb_valid, lu_wb_ready;
    logic [4:0]  lu_wb_rd;
    logic [31:0] lu_wb_data;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic [31:0] busy_mask;
    logic        sb_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_wb_scoreboard #(.MAX_PENDING(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_rd_we(issue_rd_we), .issue_long(issue_long),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lu_wb_valid(lu_wb_valid), .lu_wb_ready(lu_wb_ready),
        .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .busy_mask(busy_mask), .sb_error(sb_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_rd_we = 0; issue_long = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lu_wb_valid = 0; lu_wb_rd = 0; lu_wb_data = 0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic lng);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_rd_we = we; issue_long = lng;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_wb_valid = 1; alu_wb_rd = rd; alu_wb_data = d;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [31:0] d);
        lu_wb_valid = 1; lu_wb_rd = rd; lu_wb_data = d;
    endtask

    initial begin
        // ---- reset: everything held off, even with requests present
        rst_n = 0; idle;
        iss(1, 2, 3, 1, 0); alu(3, 32'h11); lu(4, 32'h22);
        settle;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_lu_ready", lu_wb_ready, 0);
        chk("rst_wr_en", rf_write_enable, 0);
        tick;
        chk("rst_busy", busy_mask, 0);
        chk("rst_err", sb_error, 0);
        rst_n = 1; idle; settle;
        chk("idle_issue_ready", issue_ready, 1);
        chk("idle_lu_ready", lu_wb_ready, 1);
        tick;

        // ---- short issue rd=5, ALU write-back next cycle
        idle; iss(1, 2, 5, 1, 0); settle;
        chk("s_issue_ready", issue_ready, 1);
        tick;
        idle; alu(5, 32'hDEADBEEF); iss(5, 0, 0, 0, 0); settle;
        chk("s_busy5", busy_mask, 32'h20);
        chk("s_dep_stall", issue_ready, 0);
        chk("s_wr_en", rf_write_enable, 1);
        chk("s_wr_reg", rf_write_reg, 5);
        chk("s_wr_data", rf_write_data, 32'hDEADBEEF);
        tick;
        idle; iss(5, 0, 0, 0, 0); settle;
        chk("s_busy_clr", busy_mask, 0);
        chk("s_dep_go", issue_ready, 1);
        tick;
        idle; settle;
        chk("s_err", sb_error, 0);

        // ---- long issue rd=7, dependent waits for the long accept
        idle; iss(0, 0, 7, 1, 1); settle;
        chk("l_issue_ready", issue_ready, 1);
        tick;
        idle; iss(7, 0, 0, 0, 0); settle;
        chk("l_busy7", busy_mask, 32'h80);
        chk("l_dep_stall0", issue_ready, 0);
        tick;
        settle;
        chk("l_dep_stall1", issue_ready, 0);
        tick;
        lu(7, 32'h1234); settle;
        chk("l_lu_ready", lu_wb_ready, 1);
        chk("l_wr_reg", rf_write_reg, 7);
        chk("l_wr_data", rf_write_data, 32'h1234);
        chk("l_dep_stall2", issue_ready, 0);
        tick;
        idle; iss(7, 0, 0, 0, 0); settle;
        chk("l_dep_go", issue_ready, 1);
        chk("l_busy_clr", busy_mask, 0);
        tick;

        // ---- pending limit: four long ops, fifth stalls, short still flows
        for (int i = 0; i < 4; i++) begin
            idle; iss(0, 0, 5'(10 + i), 1, 1); settle;
            chk($sformatf("p_long%0d", i), issue_ready, 1);
            tick;
        end
        idle; iss(0, 0, 14, 1, 1); settle;
        chk("p_fifth_stall", issue_ready, 0);
        idle; iss(1, 0, 0, 0, 0); settle;
        chk("p_short_go", issue_ready, 1);
        tick;
        idle; iss(0, 0, 14, 1, 1); lu(10, 32'hA); settle;
        chk("p_fifth_stall2", issue_ready, 0);
        chk("p_lu_ready", lu_wb_ready, 1);
        tick;
        idle; iss(0, 0, 14, 1, 1); settle;
        chk("p_fifth_go", issue_ready, 1);
        tick;
        for (int i = 0; i < 4; i++) begin
            idle; lu(5'(11 + i), 32'(i)); settle;
            chk($sformatf("p_drain%0d", i), lu_wb_ready, 1);
            tick;
        end
        idle; settle;
        chk("p_busy_clr", busy_mask, 0);
        chk("p_err", sb_error, 0);

        // ---- starvation guard
        idle; iss(0, 0, 20, 1, 1); tick;
        idle; iss(0, 0, 1, 1, 0); settle;
        chk("v_c0_ready", issue_ready, 1);
        tick;
        for (int k = 1; k <= 3; k++) begin
            idle; iss(0, 0, 5'(k + 1), 1, 0); alu(5'(k), 32'(k)); lu(20, 32'hCAFE); settle;
            chk($sformatf("v_c%0d_ready", k), issue_ready, 1);
            chk($sformatf("v_c%0d_lu_ready", k), lu_wb_ready, 0);
            chk($sformatf("v_c%0d_reg", k), rf_write_reg, 32'(k));
            tick;
        end
        idle; iss(0, 0, 5, 1, 0); alu(4, 32'h4); lu(20, 32'hCAFE); settle;
        chk("v_bubble", issue_ready, 0);
        chk("v_c4_lu_ready", lu_wb_ready, 0);
        tick;
        idle; iss(0, 0, 5, 1, 0); lu(20, 32'hCAFE); settle;
        chk("v_c5_ready", issue_ready, 1);
        chk("v_c5_lu_ready", lu_wb_ready, 1);
        chk("v_c5_reg", rf_write_reg, 20);
        chk("v_c5_data", rf_write_data, 32'hCAFE);
        tick;
        idle; alu(5, 32'h5); tick;
        idle; settle;
        chk("v_busy_clr", busy_mask, 0);
        chk("v_err", sb_error, 0);

        // ---- x0 destination: legal, writes and tracks nothing
        idle; iss(0, 0, 0, 1, 0); settle;
        chk("z_ready", issue_ready, 1);
        tick;
        idle; alu(0, 32'h55); settle;
        chk("z_busy", busy_mask, 0);
        chk("z_wr_en", rf_write_enable, 0);
        tick;
        idle; iss(0, 0, 0, 1, 1); tick;
        idle; lu(0, 32'h66); settle;
        chk("z_lu_ready", lu_wb_ready, 1);
        chk("z_lu_wr_en", rf_write_enable, 0);
        tick;
        idle; settle;
        chk("z_busy2", busy_mask, 0);
        chk("z_err", sb_error, 0);

        // ---- stray long write-back: sticky error until reset
        idle; lu(9, 32'h99); settle;
        chk("e_lu_ready", lu_wb_ready, 1);
        tick;
        idle; settle;
        chk("e_err_set", sb_error, 1);
        tick; tick;
        chk("e_err_sticky", sb_error, 1);
        rst_n = 0; tick;
        chk("e_err_rst", sb_error, 0);
        rst_n = 1;

        // ---- ALU write-back with no preceding short issue
        idle; alu(0, 32'h1); tick;
        idle; settle;
        chk("e_alu_err", sb_error, 1);
        rst_n = 0; tick; rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
